// File: rtl/vx_perf_memsys_counters_pkg.sv
// Shared snapshot FSM state and word-count helpers for the memsys perf counter bank.
// PERF_MEM_LATENCY_EN adds the latency accumulator as an extra snapshot word.
package VX_gpu_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } snap_state_e;

  function automatic int num_words(input int num_events);
`ifdef PERF_MEM_LATENCY_EN
    return num_events + 1;
`else
    return num_events;
`endif
  endfunction

  // Keeps the word index at least one bit wide for single-word snapshots.
  function automatic int idx_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/vx_perf_memsys_counters_ctr.sv
// VX_perf_ctr: one wide performance counter with clear, enable and wrap/saturate arithmetic.
// Used per event channel and for the latency accumulator (PERF_MEM_LATENCY_EN).
module VX_perf_ctr
  import VX_gpu_pkg::*;
#(
  parameter int CTR_BITS = 44,
  parameter int INC_BITS = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [INC_BITS-1:0] inc_i,
  output logic [CTR_BITS-1:0] count_o
);

  localparam int SUM_BITS = CTR_BITS + 1;

  logic [CTR_BITS-1:0] count_q, count_d;
  logic [CTR_BITS:0]   sum;

  // The extra top bit is the carry out, used to detect overflow for saturation.
  assign sum = {1'b0, count_q} + SUM_BITS'(inc_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      if ((SATURATE != 0) && sum[CTR_BITS]) begin
        count_d = '1;
      end else begin
        count_d = sum[CTR_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vx_perf_memsys_counters.sv
// Memory-system perf counter bank with coherent snapshot streamed over valid/ready.
// Define PERF_MEM_LATENCY_EN to integrate outstanding-request latency as the final word.
module vx_perf_memsys_counters
  import VX_gpu_pkg::*;
#(
  parameter int NUM_EVENTS = 16,
  parameter int CTR_BITS   = 44,
  parameter int INC_BITS   = 4,
  parameter int SATURATE   = 0,
  parameter int PEND_BITS  = 8,
  localparam int NUM_WORDS = num_words(NUM_EVENTS),
  localparam int IDX_BITS  = idx_bits(NUM_WORDS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [NUM_EVENTS*INC_BITS-1:0] evt_inc,
  input  logic                           mem_req_fire,
  input  logic                           mem_rsp_fire,
  input  logic                           snap_valid,
  output logic                           snap_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_BITS-1:0]            out_idx,
  output logic [CTR_BITS-1:0]            out_data,
  output logic                           out_last
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

  logic [CTR_BITS-1:0] live_w   [NUM_WORDS];
  logic [CTR_BITS-1:0] shadow_q [NUM_WORDS];

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_evt
    VX_perf_ctr #(
      .CTR_BITS (CTR_BITS),
      .INC_BITS (INC_BITS),
      .SATURATE (SATURATE)
    ) u_ctr (
      .clk_i    (clk),
      .reset_i  (reset),
      .enable_i (enable),
      .clear_i  (clear),
      .inc_i    (evt_inc[g*INC_BITS +: INC_BITS]),
      .count_o  (live_w[g])
    );
  end

`ifdef PERF_MEM_LATENCY_EN
  logic [PEND_BITS-1:0] pend_q, pend_d;

  // Pending is a tracking count, not a statistic, so clear leaves it alone.
  always_comb begin
    pend_d = pend_q;
    if (enable) begin
      if (mem_req_fire && !mem_rsp_fire && (pend_q != '1)) begin
        pend_d = pend_q + PEND_BITS'(1);
      end else if (mem_rsp_fire && !mem_req_fire && (pend_q != '0)) begin
        pend_d = pend_q - PEND_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  VX_perf_ctr #(
    .CTR_BITS (CTR_BITS),
    .INC_BITS (PEND_BITS),
    .SATURATE (SATURATE)
  ) u_lat_acc (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .clear_i  (clear),
    .inc_i    (pend_q),
    .count_o  (live_w[NUM_EVENTS])
  );
`else
  logic unused_mem_fire;
  assign unused_mem_fire = mem_req_fire ^ mem_rsp_fire;
`endif

  snap_state_e         state_q;
  logic [IDX_BITS-1:0] idx_q, idx_next;
  logic                snap_ready_q, out_valid_q, out_last_q;

  assign idx_next = idx_q + IDX_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        shadow_q[w] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (snap_valid) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
              shadow_q[w] <= live_w[w];
            end
            idx_q        <= '0;
            state_q      <= STREAM;
            snap_ready_q <= 1'b0;
            out_valid_q  <= 1'b1;
            out_last_q   <= (NUM_WORDS == 1);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              state_q      <= IDLE;
              snap_ready_q <= 1'b1;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
            end else begin
              idx_q      <= idx_next;
              out_last_q <= (idx_next == LAST_IDX);
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          idx_q        <= '0;
          snap_ready_q <= 1'b1;
          out_valid_q  <= 1'b0;
          out_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign snap_ready = snap_ready_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = idx_q;
  assign out_last   = out_last_q;
  assign out_data   = out_valid_q ? shadow_q[idx_q] : '0;

endmodule

// File: tb/tb_vx_perf_memsys_counters.sv
// Directed self-checking bench for vx_perf_memsys_counters (default and 8-bit wrap/saturate builds).
// Honours PERF_MEM_LATENCY_EN for the extra latency word.
module tb_vx_perf_memsys_counters;

  localparam int NE = 16;
  localparam int CB = 44;
  localparam int IB = 4;
`ifdef PERF_MEM_LATENCY_EN
  localparam int NW  = NE + 1;
  localparam int NWS = 3;
`else
  localparam int NW  = NE;
  localparam int NWS = 2;
`endif
  localparam int IW  = $clog2(NW);
  localparam int IWS = $clog2(NWS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, clear, memReqFire, memRspFire;
  logic snapValid, outReady, snapValidS, outReadyS;
  logic [NE*IB-1:0] evtInc;
  logic [2*IB-1:0]  evtIncS;

  logic          snapReady, outValid, outLast;
  logic [IW-1:0] outIdx;
  logic [CB-1:0] outData;

  logic           satReady, satValid, satLast, wrpReady, wrpValid, wrpLast;
  logic [IWS-1:0] satIdx, wrpIdx;
  logic [7:0]     satData, wrpData;

  int testsRun = 0;
  int testsFailed = 0;

  logic [CB-1:0] capData  [NW];
  logic [IW-1:0] capIdx   [NW];
  logic          capValid [NW];
  logic          capLast  [NW];
  logic          capReadyAfter, capValidAfter;

  vx_perf_memsys_counters #(
    .NUM_EVENTS(NE), .CTR_BITS(CB), .INC_BITS(IB), .SATURATE(0), .PEND_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .evt_inc(evtInc),
    .mem_req_fire(memReqFire), .mem_rsp_fire(memRspFire),
    .snap_valid(snapValid), .snap_ready(snapReady),
    .out_valid(outValid), .out_ready(outReady), .out_idx(outIdx),
    .out_data(outData), .out_last(outLast)
  );

  vx_perf_memsys_counters #(
    .NUM_EVENTS(2), .CTR_BITS(8), .INC_BITS(IB), .SATURATE(1), .PEND_BITS(8)
  ) dutSat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .evt_inc(evtIncS),
    .mem_req_fire(memReqFire), .mem_rsp_fire(memRspFire),
    .snap_valid(snapValidS), .snap_ready(satReady),
    .out_valid(satValid), .out_ready(outReadyS), .out_idx(satIdx),
    .out_data(satData), .out_last(satLast)
  );

  vx_perf_memsys_counters #(
    .NUM_EVENTS(2), .CTR_BITS(8), .INC_BITS(IB), .SATURATE(0), .PEND_BITS(8)
  ) dutWrap (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .evt_inc(evtIncS),
    .mem_req_fire(memReqFire), .mem_rsp_fire(memRspFire),
    .snap_valid(snapValidS), .snap_ready(wrpReady),
    .out_valid(wrpValid), .out_ready(outReadyS), .out_idx(wrpIdx),
    .out_data(wrpData), .out_last(wrpLast)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; memReqFire = 1'b0; memRspFire = 1'b0;
    snapValid = 1'b0; outReady = 1'b0; snapValidS = 1'b0; outReadyS = 1'b0;
    evtInc = '0; evtIncS = '0;
    tick(2);
    reset = 1'b0;
    enable = 1'b1;
  endtask

  // Accepts one snapshot and records every beat with out_ready high; pulses clear at beat clearBeat.
  task automatic captureSnapshot(input int clearBeat);
    snapValid = 1'b1;
    tick(1);
    snapValid = 1'b0;
    outReady = 1'b1;
    for (int w = 0; w < NW; w++) begin
      capValid[w] = outValid;
      capIdx[w]   = outIdx;
      capData[w]  = outData;
      capLast[w]  = outLast;
      if (w == clearBeat) clear = 1'b1;
      tick(1);
      clear = 1'b0;
    end
    capReadyAfter = snapReady;
    capValidAfter = outValid;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    reset = 1'b1;
    tick(1);
    testsRun++; if (snapReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_snap_ready: got %b expected 1", snapReady); end
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    testsRun++; if (outIdx !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", outIdx); end
    testsRun++; if (outData !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %0d expected 0", outData); end
    testsRun++; if (outLast !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_last: got %b expected 0", outLast); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [CB-1:0] expData;
    applyReset();
    evtInc[3:0] = 4'd3;
    tick(10);
    evtInc = '0;
    captureSnapshot(-1);
    for (int w = 0; w < NW; w++) begin
      expData = (w == 0) ? CB'(30) : '0;
      testsRun++; if (capValid[w] !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", w, capValid[w]); end
      testsRun++; if (capIdx[w] !== IW'(w)) begin testsFailed++; $display("[TB] FAIL basic_idx[%0d]: got %0d expected %0d", w, capIdx[w], w); end
      testsRun++; if (capData[w] !== expData) begin testsFailed++; $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", w, capData[w], expData); end
      testsRun++; if (capLast[w] !== (w == NW - 1)) begin testsFailed++; $display("[TB] FAIL basic_last[%0d]: got %b expected %b", w, capLast[w], (w == NW - 1)); end
    end
    testsRun++; if (capReadyAfter !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_ready_after: got %b expected 1", capReadyAfter); end
    testsRun++; if (capValidAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_valid_after: got %b expected 0", capValidAfter); end
  endtask

  task automatic test_enable();
    applyReset();
    enable = 1'b0;
    evtInc[3:0] = 4'd5;
    tick(4);
    evtInc = '0;
    enable = 1'b1;
    captureSnapshot(-1);
    testsRun++; if (capData[0] !== '0) begin testsFailed++; $display("[TB] FAIL enable_off_ch0: got %0d expected 0", capData[0]); end
  endtask

  task automatic test_saturate_wrap();
    logic [7:0] expSat, expWrp;
    applyReset();
    evtIncS = 8'hF0;
    tick(20);
    evtIncS = '0;
    snapValidS = 1'b1;
    tick(1);
    snapValidS = 1'b0;
    outReadyS = 1'b1;
    for (int w = 0; w < NWS; w++) begin
      expSat = (w == 1) ? 8'd255 : 8'd0;
      expWrp = (w == 1) ? 8'd44 : 8'd0;
      testsRun++; if (satValid !== 1'b1 || satIdx !== IWS'(w)) begin testsFailed++; $display("[TB] FAIL sat_beat[%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", w, satValid, satIdx, w); end
      testsRun++; if (satData !== expSat) begin testsFailed++; $display("[TB] FAIL sat_data[%0d]: got %0d expected %0d", w, satData, expSat); end
      testsRun++; if (wrpData !== expWrp) begin testsFailed++; $display("[TB] FAIL wrap_data[%0d]: got %0d expected %0d", w, wrpData, expWrp); end
      testsRun++; if (wrpLast !== (w == NWS - 1)) begin testsFailed++; $display("[TB] FAIL wrap_last[%0d]: got %b expected %b", w, wrpLast, (w == NWS - 1)); end
      tick(1);
    end
    outReadyS = 1'b0;
    testsRun++; if (satReady !== 1'b1 || wrpValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL small_return_idle: got ready=%b valid=%b expected ready=1 valid=0", satReady, wrpValid); end
  endtask

  task automatic test_clear();
    applyReset();
    evtInc[11:8] = 4'd7;
    tick(1);
    evtInc = '0;
    captureSnapshot(-1);
    testsRun++; if (capData[2] !== CB'(7)) begin testsFailed++; $display("[TB] FAIL clear_pre: got %0d expected 7", capData[2]); end
    evtInc[11:8] = 4'd5;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    evtInc = '0;
    captureSnapshot(-1);
    testsRun++; if (capData[2] !== '0) begin testsFailed++; $display("[TB] FAIL clear_wins: got %0d expected 0", capData[2]); end
    evtInc[11:8] = 4'd5;
    tick(1);
    evtInc = '0;
    captureSnapshot(0);
    testsRun++; if (capData[2] !== CB'(5)) begin testsFailed++; $display("[TB] FAIL clear_keeps_shadow: got %0d expected 5", capData[2]); end
    captureSnapshot(-1);
    testsRun++; if (capData[2] !== '0) begin testsFailed++; $display("[TB] FAIL clear_midstream_live: got %0d expected 0", capData[2]); end
  endtask

  task automatic test_stable();
    int extra;
    extra = 0;
    applyReset();
    evtInc[3:0] = 4'd1;
    tick(100);
    snapValid = 1'b1;
    tick(1); extra++;
    snapValid = 1'b0;
    outReady = 1'b0;
    testsRun++; if (outValid !== 1'b1 || outIdx !== '0 || outData !== CB'(100)) begin testsFailed++; $display("[TB] FAIL stable_first: got valid=%b idx=%0d data=%0d expected 1/0/100", outValid, outIdx, outData); end
    tick(1); extra++;
    testsRun++; if (outIdx !== '0 || outData !== CB'(100)) begin testsFailed++; $display("[TB] FAIL stable_hold0: got idx=%0d data=%0d expected 0/100", outIdx, outData); end
    outReady = 1'b1;
    tick(1); extra++;
    outReady = 1'b0;
    testsRun++; if (outIdx !== IW'(1) || outData !== '0) begin testsFailed++; $display("[TB] FAIL stable_advance: got idx=%0d data=%0d expected 1/0", outIdx, outData); end
    tick(1); extra++;
    testsRun++; if (outIdx !== IW'(1) || outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stable_hold1: got idx=%0d valid=%b expected 1/1", outIdx, outValid); end
    outReady = 1'b1;
    for (int c = 0; c < 40 && outValid; c++) begin
      tick(1); extra++;
    end
    outReady = 1'b0;
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stable_drain_timeout: got valid=%b expected 0", outValid); end
    evtInc = '0;
    captureSnapshot(-1);
    testsRun++; if (capData[0] !== CB'(100 + extra)) begin testsFailed++; $display("[TB] FAIL stable_live_count: got %0d expected %0d", capData[0], 100 + extra); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    evtInc[3:0] = 4'd1;
    snapValid = 1'b1;
    outReady = 1'b1;
    tick(1);
    testsRun++; if (outData !== '0) begin testsFailed++; $display("[TB] FAIL b2b_first_word: got %0d expected 0", outData); end
    tick(NW);
    testsRun++; if (snapReady !== 1'b1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle_gap: got ready=%b valid=%b expected 1/0", snapReady, outValid); end
    tick(1);
    testsRun++; if (outValid !== 1'b1 || outIdx !== '0) begin testsFailed++; $display("[TB] FAIL b2b_reaccept: got valid=%b idx=%0d expected 1/0", outValid, outIdx); end
    testsRun++; if (outData !== CB'(1 + NW)) begin testsFailed++; $display("[TB] FAIL b2b_second_word: got %0d expected %0d", outData, 1 + NW); end
    snapValid = 1'b0;
    evtInc = '0;
    tick(NW);
    outReady = 1'b0;
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_end: got valid=%b expected 0", outValid); end
  endtask

  task automatic test_reset_midstream();
    applyReset();
    evtInc[3:0] = 4'd2;
    tick(5);
    evtInc = '0;
    snapValid = 1'b1;
    tick(1);
    snapValid = 1'b0;
    outReady = 1'b1;
    tick(3);
    testsRun++; if (outIdx !== IW'(3)) begin testsFailed++; $display("[TB] FAIL midreset_idx3: got %0d expected 3", outIdx); end
    reset = 1'b1;
    tick(1);
    testsRun++; if (outValid !== 1'b0 || snapReady !== 1'b1 || outIdx !== '0) begin testsFailed++; $display("[TB] FAIL midreset_abort: got valid=%b ready=%b idx=%0d expected 0/1/0", outValid, snapReady, outIdx); end
    reset = 1'b0;
    outReady = 1'b0;
    captureSnapshot(-1);
    testsRun++; if (capData[0] !== '0) begin testsFailed++; $display("[TB] FAIL midreset_ctr_zero: got %0d expected 0", capData[0]); end
  endtask

`ifdef PERF_MEM_LATENCY_EN
  task automatic test_latency();
    applyReset();
    memReqFire = 1'b1;
    tick(2);
    memReqFire = 1'b0;
    tick(3);
    memRspFire = 1'b1;
    tick(2);
    memRspFire = 1'b0;
    tick(1);
    memRspFire = 1'b1;
    tick(1);
    memRspFire = 1'b0;
    tick(2);
    captureSnapshot(-1);
    testsRun++; if (capData[NE] !== CB'(10)) begin testsFailed++; $display("[TB] FAIL latency_acc: got %0d expected 10", capData[NE]); end
    testsRun++; if (capLast[NE] !== 1'b1) begin testsFailed++; $display("[TB] FAIL latency_last: got %b expected 1", capLast[NE]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_saturate_wrap();
    test_clear();
    test_stable();
    test_back_to_back();
    test_reset_midstream();
`ifdef PERF_MEM_LATENCY_EN
    test_latency();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/vx_perf_memsys_counters.md
# vx_perf_memsys_counters

- Parametrised memory-system performance counter bank: the successor to the fixed-field memsys perf interface bundle.
- Accumulates NUM_EVENTS per-cycle event increments into wide counters, with optional wrap or saturate arithmetic.
- Optionally integrates outstanding-memory-request latency.
- Exports a coherent snapshot of all counters as a serial valid/ready stream. Sits beside the cache/memory hierarchy and feeds the CSR/DCR perf readout path.

## Interface
Parameters:
- NUM_EVENTS, 16, number of event channels (≥1)
- CTR_BITS, 44, counter width (matches PERF_CTR_BITS)
- INC_BITS, 4, width of each per-cycle increment
- SATURATE, 0, 1 = counters saturate at all-ones; 0 = wrap modulo 2^CTR_BITS
- PEND_BITS, 8, width of the outstanding-request counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  counting enable; when 0 no counter or pending state changes
- clear  in  1  zero all live counters
- evt_inc  in  NUM_EVENTS*INC_BITS  per-event increment, channel i at [i*INC_BITS +: INC_BITS]
- mem_req_fire  in  1  memory request accepted this cycle
- mem_rsp_fire  in  1  memory response accepted this cycle
- snap_valid  in  1  snapshot request
- snap_ready  out  1  snapshot can be accepted
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_idx  out  $clog2(NUM_WORDS)  index of current word
- out_data  out  CTR_BITS  counter value
- out_last  out  1  final word of snapshot

NUM_WORDS = NUM_EVENTS (+1 with PERF_MEM_LATENCY_EN).

## Operation
- Live counters: ctr[i] <= ctr[i] + zero-extend(evt_inc[i]) when enable.
- Wrap mode: drop the carry. Saturate mode: clamp to all-ones; an all-ones counter never changes.
- clear: every live counter (and latency accumulator) reads 0 next cycle. Takes precedence over increments in the same cycle. Does not alter shadow registers or an in-progress stream.
- Snapshot FSM:
  - IDLE: snap_ready=1. On snap_valid&&snap_ready, shadow[i] <= ctr[i] (pre-increment value of that cycle) and go to STREAM. Increments in that cycle still land in the live counters.
  - STREAM: snap_ready=0, out_valid=1, out_idx starts at 0, out_data=shadow[out_idx]. On out_valid&&out_ready, out_idx increments. out_last = (out_idx == NUM_WORDS-1). Handshake with out_last returns to IDLE.
- Live counting continues in all states. snap_valid is ignored in STREAM.
- out_data/out_idx must hold stable while out_valid&&!out_ready.

## Timing
- Counter update latency: 1 cycle (value visible the cycle after the increment).
- Snapshot accept to first out_valid: 1 cycle. Stream throughput: 1 word/cycle with out_ready held high. A full snapshot takes NUM_WORDS+1 cycles from accept to return to IDLE.
- Back-to-back snapshots: snap_ready reasserts the cycle after the last beat.
- Reset values: all counters, shadows, pending and accumulator 0; state IDLE; snap_ready=1; out_valid=0; out_idx=0; out_data=0; out_last=0.
- Reset mid-stream aborts the stream immediately (out_valid=0 next cycle).

## Configuration
- PERF_MEM_LATENCY_EN defined:
  - pending counter updates as +1 on req only, −1 on rsp only, unchanged on both or neither.
  - rsp at pending=0 holds 0; req at all-ones holds all-ones.
  - lat_acc += pending (registered value) each enabled cycle, following SATURATE arithmetic.
  - lat_acc is snapshotted and streamed as the final word, idx NUM_EVENTS.
- PERF_MEM_LATENCY_EN undefined: no pending/accumulator logic; mem_req_fire and mem_rsp_fire ignored; NUM_WORDS = NUM_EVENTS.

## Structure
- Shared package (VX_gpu_pkg): snapshot FSM state enum (IDLE, STREAM); a NUM_WORDS helper function.
- Sub-module VX_perf_ctr: one counter with inc/clear/enable and a SATURATE parameter. It is instantiated per event and for lat_acc.

## Test plan
- evt_inc ch0=3 for 10 cycles, enable=1 -> snapshot streams word0=30; others 0; out_last on idx NUM_WORDS-1.
- CTR_BITS=8, SATURATE=1, ch1=15 for 20 cycles -> 255. Same with SATURATE=0 -> 300 mod 256 = 44.
- clear asserted with ch2=5 in the same cycle after ch2 reached 7 -> next cycle ch2=0, and the cycle after reads 5 if inc continues.
- Snapshot accepted while ch0 increments by 1 each cycle, from 100 -> word0=100 streamed. Live ch0 keeps counting; out_ready toggled 0/1 holds data stable.
- PERF_MEM_LATENCY_EN: 2 reqs on cycles 0,1; rsps on cycles 5,6 -> lat_acc = 1+2+2+2+2+1 = 10. An rsp at pending=0 leaves pending 0.
- reset asserted at out_idx=3 -> next cycle out_valid=0, snap_ready=1, all counters 0.
